// File: rtl/uart_frame_ctrl.sv
// uart_frame_ctrl: sequences uart_rx byte strobes into header/cmd/len/payload/checksum frames
//   sys_clk      in   system clock, rising edge
//   sys_rst_n    in   synchronous active-low reset
//   pi_data[7:0] in   received byte, qualified by pi_flag
//   pi_flag      in   one-cycle received-byte strobe
//   frame_ack    in   consumer accepts the held frame
//   wr_en        out  payload buffer write strobe
//   wr_addr[3:0] out  payload index
//   wr_data[7:0] out  payload byte
//   frame_cmd    out  command byte of the frame
//   frame_len    out  payload length, 0..16
//   frame_valid  out  validated frame held until frame_ack
//   frame_err    out  one-cycle error pulse
//   err_code     out  last error: 01 checksum, 10 length, 11 timeout
//   drop_flag    out  one-cycle pulse for a byte discarded while holding
//   busy         out  high whenever the controller is not idle
module uart_frame_ctrl #(
   parameter int         CLK_FREQ      = 50_000_000,
   parameter int         UART_BPS      = 9600,
   parameter logic [7:0] HEADER        = 8'h55,
   parameter int         MAX_LEN       = 16,
   parameter int         TIMEOUT_BYTES = 3
) (
   input  logic       sys_clk,
   input  logic       sys_rst_n,
   input  logic [7:0] pi_data,
   input  logic       pi_flag,
   input  logic       frame_ack,
   output logic       wr_en,
   output logic [3:0] wr_addr,
   output logic [7:0] wr_data,
   output logic [7:0] frame_cmd,
   output logic [4:0] frame_len,
   output logic       frame_valid,
   output logic       frame_err,
   output logic [1:0] err_code,
   output logic       drop_flag,
   output logic       busy
);
   localparam int TIMEOUT_CNT = (CLK_FREQ / UART_BPS) * 10 * TIMEOUT_BYTES;
   localparam int CNT_W = $clog2(TIMEOUT_CNT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CNT - 1);
   localparam logic [7:0] LEN_MAX = 8'(MAX_LEN);
   typedef enum logic [2:0] {IDLE, CMD, LEN, PAYLOAD, CHK, HOLD} state_t;
   state_t           state, state_nxt;
   logic [7:0]       sum, sum_nxt;
   logic [3:0]       idx, idx_nxt;
   logic [CNT_W-1:0] to_cnt, to_cnt_nxt;
   logic             active, timeout;
   logic             wr_en_nxt, frame_valid_nxt, frame_err_nxt, drop_flag_nxt;
   logic [3:0]       wr_addr_nxt;
   logic [7:0]       wr_data_nxt, frame_cmd_nxt;
   logic [4:0]       frame_len_nxt;
   logic [1:0]       err_code_nxt;
   always_comb begin
      active          = (state == CMD) || (state == LEN) || (state == PAYLOAD) || (state == CHK);
      // a byte arriving on the threshold cycle beats the timeout
      timeout         = active && !pi_flag && (to_cnt == CNT_LAST);
      to_cnt_nxt      = (active && !pi_flag && !timeout) ? to_cnt + CNT_W'(1) : '0;
      state_nxt       = state;
      sum_nxt         = sum;
      idx_nxt         = idx;
      wr_en_nxt       = 1'b0;
      wr_addr_nxt     = wr_addr;
      wr_data_nxt     = wr_data;
      frame_cmd_nxt   = frame_cmd;
      frame_len_nxt   = frame_len;
      frame_valid_nxt = frame_valid;
      frame_err_nxt   = 1'b0;
      err_code_nxt    = err_code;
      drop_flag_nxt   = 1'b0;
      if (timeout) begin
         state_nxt     = IDLE;
         frame_err_nxt = 1'b1;
         err_code_nxt  = 2'b11;
      end else begin
         case (state)
            IDLE: if (pi_flag && pi_data == HEADER) state_nxt = CMD;
            CMD: if (pi_flag) begin
               frame_cmd_nxt = pi_data;
               sum_nxt       = pi_data;
               state_nxt     = LEN;
            end
            LEN: if (pi_flag) begin
               if (pi_data > LEN_MAX) begin
                  frame_err_nxt = 1'b1;
                  err_code_nxt  = 2'b10;
                  state_nxt     = IDLE;
               end else begin
                  frame_len_nxt = pi_data[4:0];
                  sum_nxt       = sum + pi_data;
                  idx_nxt       = 4'd0;
                  state_nxt     = (pi_data == 8'd0) ? CHK : PAYLOAD;
               end
            end
            PAYLOAD: if (pi_flag) begin
               wr_en_nxt   = 1'b1;
               wr_addr_nxt = idx;
               wr_data_nxt = pi_data;
               sum_nxt     = sum + pi_data;
               // idx wraps to 0 after a 16-byte payload, harmless since we leave PAYLOAD
               idx_nxt     = idx + 4'd1;
               if ({1'b0, idx} == frame_len - 5'd1) state_nxt = CHK;
            end
            CHK: if (pi_flag) begin
               if (pi_data == sum) begin
                  frame_valid_nxt = 1'b1;
                  state_nxt       = HOLD;
               end else begin
                  frame_err_nxt = 1'b1;
                  err_code_nxt  = 2'b01;
                  state_nxt     = IDLE;
               end
            end
            HOLD: begin
               drop_flag_nxt = pi_flag;
               if (frame_ack) begin
                  frame_valid_nxt = 1'b0;
                  state_nxt       = IDLE;
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end
   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         state       <= IDLE;
         sum         <= '0;
         idx         <= '0;
         to_cnt      <= '0;
         wr_en       <= 1'b0;
         wr_addr     <= '0;
         wr_data     <= '0;
         frame_cmd   <= '0;
         frame_len   <= '0;
         frame_valid <= 1'b0;
         frame_err   <= 1'b0;
         err_code    <= '0;
         drop_flag   <= 1'b0;
         busy        <= 1'b0;
      end else begin
         state       <= state_nxt;
         sum         <= sum_nxt;
         idx         <= idx_nxt;
         to_cnt      <= to_cnt_nxt;
         wr_en       <= wr_en_nxt;
         wr_addr     <= wr_addr_nxt;
         wr_data     <= wr_data_nxt;
         frame_cmd   <= frame_cmd_nxt;
         frame_len   <= frame_len_nxt;
         frame_valid <= frame_valid_nxt;
         frame_err   <= frame_err_nxt;
         err_code    <= err_code_nxt;
         drop_flag   <= drop_flag_nxt;
         busy        <= (state_nxt != IDLE);
      end
   end
endmodule

// File: tb/tb_uart_frame_ctrl.sv
// tb_uart_frame_ctrl: table vectors, timeout/reset sequences and random frames against a queue-based frame model
module tb_uart_frame_ctrl;
   localparam logic [7:0] HDR = 8'h55;
   localparam int TO_CNT = (1000 / 100) * 10 * 1;
   logic       sys_clk, sys_rst_n, pi_flag, frame_ack;
   logic [7:0] pi_data;
   logic       wr_en, frame_valid, frame_err, drop_flag, busy;
   logic [3:0] wr_addr;
   logic [7:0] wr_data, frame_cmd;
   logic [4:0] frame_len;
   logic [1:0] err_code;
   int checks = 0;
   int errors = 0;
   uart_frame_ctrl #(.CLK_FREQ(1000), .UART_BPS(100), .HEADER(HDR), .MAX_LEN(16), .TIMEOUT_BYTES(1)) dut (
      .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .pi_data(pi_data), .pi_flag(pi_flag),
      .frame_ack(frame_ack), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .frame_cmd(frame_cmd), .frame_len(frame_len), .frame_valid(frame_valid),
      .frame_err(frame_err), .err_code(err_code), .drop_flag(drop_flag), .busy(busy)
   );
   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;
   typedef struct {
      logic        f;
      logic [7:0]  d;
      logic        a;
      logic [31:0] exp;
   } vec_t;
   vec_t tbl[$];
   // reference model: bytes of the frame being collected, plus what the outputs should show
   logic [7:0] cur[$];
   logic       holding;
   int         since;
   logic       m_wr, m_err, m_valid, m_drop;
   logic [3:0] m_addr;
   logic [7:0] m_data, m_cmd;
   logic [4:0] m_len;
   logic [1:0] m_code;
   function automatic logic [31:0] pk(input logic w, input logic [3:0] ad, input logic [7:0] dt,
                                      input logic e, input logic [1:0] c, input logic v,
                                      input logic [7:0] cm, input logic [4:0] ln, input logic dr,
                                      input logic b);
      return {w, w ? ad : 4'h0, w ? dt : 8'h0, e, c, v, cm, ln, dr, b};
   endfunction
   function automatic logic [31:0] dut_vec();
      return pk(wr_en, wr_addr, wr_data, frame_err, err_code, frame_valid, frame_cmd, frame_len, drop_flag, busy);
   endfunction
   function automatic logic [31:0] model_vec();
      return pk(m_wr, m_addr, m_data, m_err, m_code, m_valid, m_cmd, m_len, m_drop, holding || cur.size() != 0);
   endfunction
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h want %h", name, act, exp);
      end
   endtask
   task automatic fail_frame(input logic [1:0] c);
      m_err  = 1'b1;
      m_code = c;
      cur.delete();
   endtask
   task automatic model_step(input logic f, input logic [7:0] d, input logic a);
      int n;
      logic [7:0] s;
      m_wr   = 1'b0;
      m_err  = 1'b0;
      m_drop = 1'b0;
      since  = f ? 0 : since + 1;
      if (holding) begin
         m_drop = f;
         if (a) begin
            holding = 1'b0;
            m_valid = 1'b0;
         end
      end else if (f) begin
         if (cur.size() == 0) begin
            if (d == HDR) cur.push_back(d);
         end else begin
            cur.push_back(d);
            n = cur.size();
            if (n == 2) m_cmd = d;
            else if (n == 3) begin
               if (d > 8'd16) fail_frame(2'b10);
               else m_len = d[4:0];
            end else if (n < 4 + int'(cur[2])) begin
               m_wr   = 1'b1;
               m_addr = 4'(n - 4);
               m_data = d;
            end else begin
               s = 8'h00;
               for (int i = 1; i < n - 1; i++) s += cur[i];
               if (s == d) begin
                  m_valid = 1'b1;
                  holding = 1'b1;
                  cur.delete();
               end else fail_frame(2'b01);
            end
         end
      end else if (cur.size() != 0 && since == TO_CNT) fail_frame(2'b11);
   endtask
   task automatic tick(input logic f, input logic [7:0] d, input logic a);
      pi_flag   = f;
      pi_data   = d;
      frame_ack = a;
      model_step(f, d, a);
      @(posedge sys_clk);
      #1;
      pi_flag   = 1'b0;
      frame_ack = 1'b0;
      check("model", dut_vec(), model_vec());
   endtask
   task automatic do_reset();
      sys_rst_n = 1'b0;
      pi_flag   = 1'b0;
      frame_ack = 1'b0;
      @(posedge sys_clk);
      #1;
      sys_rst_n = 1'b1;
      cur.delete();
      holding = 0; since = 0;
      m_wr = 0; m_err = 0; m_valid = 0; m_drop = 0;
      m_addr = 0; m_data = 0; m_cmd = 0; m_len = 0; m_code = 0;
      check("reset", dut_vec(), 32'h0);
   endtask
   task automatic r(input logic f, input logic [7:0] d, input logic a, input logic w, input logic [3:0] ad,
                    input logic [7:0] dt, input logic e, input logic [1:0] c, input logic v,
                    input logic [7:0] cm, input logic [4:0] ln, input logic dr, input logic b);
      vec_t x;
      x.f = f; x.d = d; x.a = a;
      x.exp = pk(w, ad, dt, e, c, v, cm, ln, dr, b);
      tbl.push_back(x);
   endtask
   task automatic send(input logic [7:0] q[$], input int max_gap);
      foreach (q[i]) begin
         tick(1'b1, q[i], 1'b0);
         repeat ($urandom_range(0, max_gap)) tick(1'b0, 8'h00, 1'b0);
      end
   endtask
   initial begin
      logic [7:0] q[$];
      logic [7:0] s, cm, b;
      int kind, ln;
      pi_flag = 0; pi_data = 0; frame_ack = 0; sys_rst_n = 0;
      // good frame, ack
      r(1, 8'h55, 0, 0, 0, 8'h00, 0, 2'd0, 0, 8'h00, 5'd0, 0, 1);
      r(1, 8'h01, 0, 0, 0, 8'h00, 0, 2'd0, 0, 8'h01, 5'd0, 0, 1);
      r(1, 8'h02, 0, 0, 0, 8'h00, 0, 2'd0, 0, 8'h01, 5'd2, 0, 1);
      r(1, 8'hAA, 0, 1, 0, 8'hAA, 0, 2'd0, 0, 8'h01, 5'd2, 0, 1);
      r(1, 8'hBB, 0, 1, 1, 8'hBB, 0, 2'd0, 0, 8'h01, 5'd2, 0, 1);
      r(1, 8'h68, 0, 0, 0, 8'h00, 0, 2'd0, 1, 8'h01, 5'd2, 0, 1);
      r(0, 8'h00, 1, 0, 0, 8'h00, 0, 2'd0, 0, 8'h01, 5'd2, 0, 0);
      // bad checksum
      r(1, 8'h55, 0, 0, 0, 8'h00, 0, 2'd0, 0, 8'h01, 5'd2, 0, 1);
      r(1, 8'h01, 0, 0, 0, 8'h00, 0, 2'd0, 0, 8'h01, 5'd2, 0, 1);
      r(1, 8'h02, 0, 0, 0, 8'h00, 0, 2'd0, 0, 8'h01, 5'd2, 0, 1);
      r(1, 8'hAA, 0, 1, 0, 8'hAA, 0, 2'd0, 0, 8'h01, 5'd2, 0, 1);
      r(1, 8'hBB, 0, 1, 1, 8'hBB, 0, 2'd0, 0, 8'h01, 5'd2, 0, 1);
      r(1, 8'h69, 0, 0, 0, 8'h00, 1, 2'd1, 0, 8'h01, 5'd2, 0, 0);
      r(0, 8'h00, 0, 0, 0, 8'h00, 0, 2'd1, 0, 8'h01, 5'd2, 0, 0);
      // length 17 rejected, then a zero-length frame
      r(1, 8'h55, 0, 0, 0, 8'h00, 0, 2'd1, 0, 8'h01, 5'd2, 0, 1);
      r(1, 8'h03, 0, 0, 0, 8'h00, 0, 2'd1, 0, 8'h03, 5'd2, 0, 1);
      r(1, 8'h11, 0, 0, 0, 8'h00, 1, 2'd2, 0, 8'h03, 5'd2, 0, 0);
      r(1, 8'h55, 0, 0, 0, 8'h00, 0, 2'd2, 0, 8'h03, 5'd2, 0, 1);
      r(1, 8'h04, 0, 0, 0, 8'h00, 0, 2'd2, 0, 8'h04, 5'd2, 0, 1);
      r(1, 8'h00, 0, 0, 0, 8'h00, 0, 2'd2, 0, 8'h04, 5'd0, 0, 1);
      r(1, 8'h04, 0, 0, 0, 8'h00, 0, 2'd2, 1, 8'h04, 5'd0, 0, 1);
      r(0, 8'h00, 1, 0, 0, 8'h00, 0, 2'd2, 0, 8'h04, 5'd0, 0, 0);
      // garbage, good frame, byte dropped during hold
      r(1, 8'h00, 0, 0, 0, 8'h00, 0, 2'd2, 0, 8'h04, 5'd0, 0, 0);
      r(1, 8'hFF, 0, 0, 0, 8'h00, 0, 2'd2, 0, 8'h04, 5'd0, 0, 0);
      r(1, 8'h12, 0, 0, 0, 8'h00, 0, 2'd2, 0, 8'h04, 5'd0, 0, 0);
      r(1, 8'h55, 0, 0, 0, 8'h00, 0, 2'd2, 0, 8'h04, 5'd0, 0, 1);
      r(1, 8'h0A, 0, 0, 0, 8'h00, 0, 2'd2, 0, 8'h0A, 5'd0, 0, 1);
      r(1, 8'h01, 0, 0, 0, 8'h00, 0, 2'd2, 0, 8'h0A, 5'd1, 0, 1);
      r(1, 8'h5C, 0, 1, 0, 8'h5C, 0, 2'd2, 0, 8'h0A, 5'd1, 0, 1);
      r(1, 8'h67, 0, 0, 0, 8'h00, 0, 2'd2, 1, 8'h0A, 5'd1, 0, 1);
      r(1, 8'h33, 0, 0, 0, 8'h00, 0, 2'd2, 1, 8'h0A, 5'd1, 1, 1);
      r(0, 8'h00, 0, 0, 0, 8'h00, 0, 2'd2, 1, 8'h0A, 5'd1, 0, 1);
      r(0, 8'h00, 1, 0, 0, 8'h00, 0, 2'd2, 0, 8'h0A, 5'd1, 0, 0);
      @(posedge sys_clk);
      #1;
      do_reset();
      for (int i = 0; i < tbl.size(); i++) begin
         tick(tbl[i].f, tbl[i].d, tbl[i].a);
         check($sformatf("tbl%0d", i), dut_vec(), tbl[i].exp);
      end
      // timeout fires exactly TO_CNT cycles after the last strobe
      tick(1'b1, HDR, 1'b0);
      tick(1'b1, 8'h07, 1'b0);
      for (int k = 1; k <= TO_CNT; k++) begin
         tick(1'b0, 8'h00, 1'b0);
         if (k >= TO_CNT - 1)
            check($sformatf("timeout_k%0d", k), {frame_err, err_code, busy},
                  (k == TO_CNT) ? {1'b1, 2'b11, 1'b0} : {1'b0, 2'b10, 1'b1});
      end
      // a byte on the threshold cycle is taken instead
      tick(1'b1, HDR, 1'b0);
      tick(1'b1, 8'h07, 1'b0);
      repeat (TO_CNT - 1) tick(1'b0, 8'h00, 1'b0);
      tick(1'b1, 8'h02, 1'b0);
      check("timeout_win", {frame_err, busy, frame_len}, {1'b0, 1'b1, 5'd2});
      tick(1'b1, 8'hAA, 1'b0);
      tick(1'b1, 8'hBB, 1'b0);
      tick(1'b1, 8'h6E, 1'b0);
      check("timeout_frame", {frame_valid, frame_cmd, frame_len}, {1'b1, 8'h07, 5'd2});
      tick(1'b0, 8'h00, 1'b1);
      // reset in the middle of a payload
      send('{HDR, 8'h01, 8'h03, 8'hAA, 8'hBB}, 0);
      do_reset();
      send('{HDR, 8'h01, 8'h02, 8'hAA, 8'hBB, 8'h68}, 0);
      check("after_reset", {frame_valid, frame_cmd, frame_len, busy}, {1'b1, 8'h01, 5'd2, 1'b1});
      tick(1'b0, 8'h00, 1'b1);
      // random frames
      for (int fr = 0; fr < 80; fr++) begin
         kind = $urandom_range(0, 9);
         cm = 8'($urandom);
         ln = $urandom_range(0, 4);
         ln = (ln == 0) ? 0 : (ln == 1) ? 16 : $urandom_range(1, 15);
         q = '{HDR, cm, 8'(ln)};
         s = cm + 8'(ln);
         for (int i = 0; i < ln; i++) begin
            b = 8'($urandom);
            q.push_back(b);
            s += b;
         end
         if (kind <= 4) begin
            q.push_back(s);
            send(q, 3);
            repeat ($urandom_range(0, 2)) tick(1'b1, 8'($urandom), 1'b0);
            tick(1'b0, 8'h00, 1'b1);
         end else if (kind == 5) begin
            q.push_back(s + 8'($urandom_range(1, 255)));
            send(q, 3);
         end else if (kind == 6) begin
            send('{HDR, cm, 8'($urandom_range(17, 255))}, 3);
         end else if (kind == 7) begin
            q.delete();
            repeat ($urandom_range(1, 3)) begin
               b = 8'($urandom);
               q.push_back((b == HDR) ? 8'h00 : b);
            end
            send(q, 3);
         end else if (kind == 8) begin
            q = q[0:$urandom_range(0, q.size() - 1)];
            send(q, 3);
            repeat (TO_CNT + $urandom_range(0, 5)) tick(1'b0, 8'h00, 1'b0);
         end else tick(1'b0, 8'h00, 1'b1);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/uart_frame_ctrl.md
Name: uart_frame_ctrl

Overview:
Frame-level controller that sequences the byte stream from the UART receiver (pi_data/pi_flag one-cycle strobes) into command frames. It hunts for a header, captures command and length, writes payload bytes to an external 16-entry buffer, verifies an additive checksum, and enforces an inter-byte timeout. A validated frame is held for the downstream command executor until acknowledged. Sits between uart_rx and the command/register logic.

Parameters:
CLK_FREQ, 50_000_000, system clock frequency in Hz.
UART_BPS, 9600, line baud rate; must match the receiver.
HEADER, 8'h55, frame start byte.
MAX_LEN, 16, maximum payload length; must be ≤16.
TIMEOUT_BYTES, 3, inter-byte timeout in character times (10 bits each).
Derived localparam: TIMEOUT_CNT = (CLK_FREQ/UART_BPS)*10*TIMEOUT_BYTES; the counter is sized by $clog2(TIMEOUT_CNT).

Ports:
sys_clk  input  1  system clock; all logic is on the rising edge.
sys_rst_n  input  1  reset, synchronous, active-low.
pi_data  input  8  received byte; valid only when pi_flag is high.
pi_flag  input  1  one-cycle strobe marking a received byte.
frame_ack  input  1  consumer accepts the held frame.
wr_en  output  1  payload buffer write strobe.
wr_addr  output  4  payload index, 0..len-1.
wr_data  output  8  payload byte.
frame_cmd  output  8  command byte of the held frame.
frame_len  output  5  payload length of the held frame, 0..16.
frame_valid  output  1  held frame ready; level signal.
frame_err  output  1  one-cycle error pulse.
err_code  output  2  last error: 01 checksum, 10 length, 11 timeout.
drop_flag  output  1  one-cycle pulse when a byte arrives during HOLD.
busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (sys_rst_n low at a clock edge): state goes to IDLE. All outputs, the checksum, the index, and the timeout counter clear to 0. Reset takes effect from any state, including mid-payload.
- All outputs are registered. The response appears one cycle after the pi_flag cycle that causes it.
- State machine:
  - IDLE: on pi_flag with pi_data==HEADER, go to CMD. Any other byte is ignored, with no error.
  - CMD: on pi_flag, frame_cmd<=pi_data and sum<=pi_data; go to LEN.
  - LEN: on pi_flag:
    - If pi_data>MAX_LEN: frame_err pulse, err_code<=10, go to IDLE.
    - Otherwise: frame_len<=pi_data[4:0], sum<=sum+pi_data, idx<=0. Go to CHK if pi_data==0, else go to PAYLOAD.
  - PAYLOAD: on pi_flag, the next cycle has wr_en=1, wr_addr=idx, wr_data=pi_data. Also sum<=sum+pi_data and idx<=idx+1. When idx==frame_len-1, go to CHK.
  - CHK: on pi_flag:
    - If pi_data==sum: frame_valid<=1, go to HOLD.
    - Otherwise: frame_err pulse, err_code<=01, go to IDLE.
  - HOLD: frame_valid stays high and frame_cmd/frame_len are stable. When frame_ack is sampled high, frame_valid<=0 on the next edge and the state goes to IDLE. A pi_flag in HOLD is discarded with a drop_flag pulse.
- Checksum: 8-bit sum of cmd, len and all payload bytes, modulo 256, with carries discarded.
- frame_ack outside HOLD is ignored.
- Timeout:
  - Active only in CMD, LEN, PAYLOAD and CHK. The counter clears in IDLE and HOLD.
  - The counter clears on every pi_flag and otherwise increments each cycle.
  - When the counter reaches TIMEOUT_CNT-1 with no pi_flag in that cycle: frame_err pulse, err_code<=11, go to IDLE.
  - If pi_flag and the timeout threshold fall in the same cycle, pi_flag wins: the byte is processed and the counter clears.
- Errors:
  - On any error, payload writes already issued are not rolled back. The consumer must trust buffer contents only while frame_valid is high.
  - err_code holds its value until the next error or reset.
  - frame_err and frame_valid are never high together.
- wr_en, frame_err and drop_flag are single-cycle pulses.
- busy is combinational-free: it is registered from the next state.

Test Plan:
1. Stream 55 01 02 AA BB 68 → wr_en twice (addr0=AA, addr1=BB); frame_valid=1 one cycle after the 68 strobe, with frame_cmd=01 and frame_len=2. Pulse frame_ack → frame_valid=0 next cycle, busy=0.
2. Stream 55 01 02 AA BB 69 → frame_err pulse with err_code=01; frame_valid stays 0; state returns to IDLE.
3. Stream 55 03 11 (17>MAX_LEN) → frame_err with err_code=10; no wr_en. A following 55 04 00 04 → frame_valid with frame_len=0 and no wr_en.
4. Use CLK_FREQ=1000, UART_BPS=100, TIMEOUT_BYTES=1 (TIMEOUT_CNT=100). Send 55 07, then silence → frame_err with err_code=11 exactly 100 cycles after the 07 strobe. A byte strobed on cycle 99 instead is accepted, with no error.
5. Send leading garbage 00 FF 12, then a valid frame → garbage ignored, frame accepted. While in HOLD, send 33 → drop_flag pulse; frame_cmd/frame_len unchanged.
6. Assert sys_rst_n=0 for one cycle mid-payload → all outputs 0, busy=0. The next complete valid frame is accepted correctly.
